// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; busy stalls issue for WIDTH cycles.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             we_hi,
  input  logic             we_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             div0;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_raw;

  // operand conditioning for launch: signed ops iterate on magnitudes
  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    sgn_op = ~op[0];
    sa     = sgn_op & srca[WIDTH-1];
    sb     = sgn_op & srcb[WIDTH-1];
    mag_a  = sa ? (~srca + 1'b1) : srca;
    mag_b  = sb ? (~srcb + 1'b1) : srcb;
  end

  // one iteration of the datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] qr_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, (qr[0] ? m : {WIDTH{1'b0}})};
    div_shift = {acc, qr[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, m};
    div_sub   = div_shift[WIDTH-1:0] - m;
    if (is_div) begin
      acc_nxt = div_ge ? div_sub : div_shift[WIDTH-1:0];
      qr_nxt  = {qr[WIDTH-2:0], div_ge};
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      qr_nxt  = {mul_sum[0], qr[WIDTH-1:1]};
    end
  end

  // final sign fix-up, evaluated on the values produced by the last iteration
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod_mag = {acc_nxt, qr_nxt};
    prod     = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    quot     = neg_q ? (~qr_nxt + 1'b1) : qr_nxt;
    rem      = neg_r ? (~acc_nxt + 1'b1) : acc_nxt;
    if (div0) begin
      res_hi = a_raw;
      res_lo = {WIDTH{1'b1}};
    end else if (is_div) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      qr     <= '0;
      m      <= '0;
      a_raw  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // done from a just-finished op is held while the next one launches
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            div0   <= op[1] & (srcb == '0);
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            a_raw  <= srca;
            acc    <= '0;
            qr     <= op[1] ? mag_a : mag_b;
            m      <= op[1] ? mag_b : mag_a;
          end else begin
            done <= 1'b0;
            if (we_hi) hi <= srca;
            if (we_lo) lo <= srca;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          qr   <= qr_nxt;
          cnt  <= cnt + 1'b1;
          done <= 1'b0;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked on each done pulse.
module tb_mult_div_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        we_hi = 1'b0;
  logic        we_lo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  int          cnt;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .we_hi(we_hi), .we_lo(we_lo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pop one expected {hi,lo} on every rising done
  initial begin
    logic        prev;
    logic [63:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_hilo", {hi, lo}, e);
        end
      end
      prev = done;
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] e, input logic mv);
    int c;
    c = 0;
    start = 1'b1; op = o; srca = a; srcb = b; we_hi = mv;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; we_hi = 1'b0; srca = ~a; srcb = ~b; op = ~o;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      c++;
      if (i == 10) check("hold_during_run", {hi, lo}, {mhi, mlo});
    end
    check("busy_cycles", 64'(c), 64'd32);
    check("done_after_busy", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    mhi = e[63:32];
    mlo = e[31:0];
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", 64'({busy, done}), 64'd0);
    rst_n = 1'b1;

    // both moves together in idle
    @(posedge clk); #1;
    we_hi = 1'b1; we_lo = 1'b1; srca = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0;
    check("move_both", {hi, lo}, {32'h5A5A_0F0F, 32'h5A5A_0F0F});
    check("move_no_done", 64'(done), 64'd0);

    // asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_hilo", {hi, lo}, 64'd0);
    check("async_reset_flags", 64'({busy, done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // abort a running MULT with reset
    start = 1'b1; op = MULT; srca = 32'd5; srcb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_in_run", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", 64'({busy, done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("after_abort_hilo", {hi, lo}, 64'd0);
    check("after_abort_busy", 64'(busy), 64'd0);

    // directed arithmetic vectors
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    run_op(MULT,  32'hFFFF_FFFE, 32'h0000_0003, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b0);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op(DIV,   32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    run_op(DIVU,  32'h1234_5678, 32'h0000_0000, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0000, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0);
    // start together with mthi: start wins
    run_op(MULTU, 32'h0000_0002, 32'h0000_0003, {32'h0000_0000, 32'h0000_0006}, 1'b1);

    // start held high: back-to-back launch
    start = 1'b1; op = MULTU; srca = 32'd3; srcb = 32'd5;
    exp_q.push_back({32'd0, 32'd15});
    exp_q.push_back({32'd2, 32'd14});
    @(posedge clk); #1;
    op = DIVU; srca = 32'd100; srcb = 32'd7;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("b2b_busy_cycles", 64'(cnt), 64'd32);
    check("b2b_first_done", 64'(done), 64'd1);
    @(negedge clk);
    check("b2b_busy_and_done", 64'({busy, done}), 64'd3);
    start = 1'b0;
    mhi = 32'd0; mlo = 32'd15;

    // mtlo while busy is ignored
    we_lo = 1'b1; srca = 32'hAAAA_5555;
    repeat (3) @(negedge clk);
    we_lo = 1'b0;
    check("hold_during_b2b", {hi, lo}, {mhi, mlo});
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("b2b_second_ends", 64'(busy), 64'd0);
    check("mtlo_busy_ignored", 64'(lo), 64'd14);
    mhi = 32'd2; mlo = 32'd14;

    // mtlo in idle
    @(posedge clk); #1;
    we_lo = 1'b1; srca = 32'hAAAA_5555;
    @(posedge clk); #1;
    we_lo = 1'b0;
    check("mtlo_idle", {hi, lo}, {32'd2, 32'hAAAA_5555});
    @(negedge clk);
    check("mtlo_no_done", 64'(done), 64'd0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
